// File: rtl/lcd_write_if.sv
// Bus between the LSU's LCD output register and the LCD write controller.
// Carries the request word and strobe in one direction, and the LCD pins and status flags in the other.
interface lcd_write_if;
    logic [31:0] i_lcd_word;
    logic        i_lcd_wren;
    logic [7:0]  o_lcd_data;
    logic        o_lcd_rs;
    logic        o_lcd_rw;
    logic        o_lcd_en;
    logic        o_lcd_on;
    logic        o_busy;
    logic        o_done;
    logic        o_overrun;

    modport master (
        output i_lcd_word, i_lcd_wren,
        input  o_lcd_data, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on,
        input  o_busy, o_done, o_overrun
    );

    modport slave (
        input  i_lcd_word, i_lcd_wren,
        output o_lcd_data, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on,
        output o_busy, o_done, o_overrun
    );
endinterface

// File: rtl/lcd_write_ctrl.sv
// HD44780 write controller: turns one LSU command word into a timed SETUP/EN/HOLD/EXEC bus cycle.
// Define LCD_INIT_EN to run the power-on init sequence (0x38, 0x0C, 0x01, 0x06) after reset.
module lcd_write_ctrl #(
    parameter int SETUP_CYC     = 4,
    parameter int EN_CYC        = 12,
    parameter int HOLD_CYC      = 4,
    parameter int EXEC_CYC      = 1850,
    parameter int EXEC_LONG_CYC = 76000,
    parameter int INIT_WAIT_CYC = 750000
) (
    input  logic         i_clk,
    input  logic         i_rst,
    lcd_write_if.slave   bus
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_CYC = max2(max2(max2(SETUP_CYC, EN_CYC), max2(HOLD_CYC, EXEC_CYC)),
                                  max2(EXEC_LONG_CYC, INIT_WAIT_CYC));
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t SETUP_LAST     = cnt_t'(SETUP_CYC - 1);
    localparam cnt_t EN_LAST        = cnt_t'(EN_CYC - 1);
    localparam cnt_t HOLD_LAST      = cnt_t'(HOLD_CYC - 1);
    localparam cnt_t EXEC_LAST      = cnt_t'(EXEC_CYC - 1);
    localparam cnt_t EXEC_LONG_LAST = cnt_t'(EXEC_LONG_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_EXEC
`ifdef LCD_INIT_EN
        , ST_INIT_WAIT
`endif
    } state_t;

`ifdef LCD_INIT_EN
    localparam state_t RESET_STATE = ST_INIT_WAIT;
    localparam cnt_t   INIT_LAST   = cnt_t'(INIT_WAIT_CYC - 1);

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction
`else
    localparam state_t RESET_STATE = ST_IDLE;
`endif

    state_t      state_q, state_d;
    cnt_t        cnt_q, cnt_d;
    logic        rs_q, rs_d;
    logic [7:0]  data_q, data_d;
    logic        on_q, on_d;
    logic        en_q, en_d;
    logic        done_q, done_d;
    logic        ovr_q, ovr_d;
    logic        pend_vld_q, pend_vld_d;
    logic        pend_rs_q, pend_rs_d;
    logic [7:0]  pend_data_q, pend_data_d;
    logic        pend_on_q, pend_on_d;
`ifdef LCD_INIT_EN
    logic [1:0]  init_idx_q, init_idx_d;
    logic        cur_init_q, cur_init_d;
`endif

    logic        launch;
    logic        from_pend;
    logic        finish;
    logic        direct;
    logic        l_rs;
    logic [7:0]  l_data;
    logic        l_on;
    logic        is_long_cmd;
    cnt_t        exec_last;

    // Only the on bit, RS and the data byte are meaningful in the command word.
    logic        unused_word_bits;
    assign unused_word_bits = ^{bus.i_lcd_word[30:10], bus.i_lcd_word[8]};

    // Clear display and return home need the long execution time.
    assign is_long_cmd = !rs_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);
    assign exec_last   = is_long_cmd ? EXEC_LONG_LAST : EXEC_LAST;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        rs_d        = rs_q;
        data_d      = data_q;
        on_d        = on_q;
        done_d      = 1'b0;
        ovr_d       = ovr_q;
        pend_vld_d  = pend_vld_q;
        pend_rs_d   = pend_rs_q;
        pend_data_d = pend_data_q;
        pend_on_d   = pend_on_q;
`ifdef LCD_INIT_EN
        init_idx_d  = init_idx_q;
        cur_init_d  = cur_init_q;
`endif
        launch      = 1'b0;
        from_pend   = 1'b0;
        finish      = 1'b0;
        l_rs        = 1'b0;
        l_data      = 8'h00;
        l_on        = 1'b0;
        direct      = (state_q == ST_IDLE) && !pend_vld_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (pend_vld_q) begin
                    launch    = 1'b1;
                    from_pend = 1'b1;
                    l_rs      = pend_rs_q;
                    l_data    = pend_data_q;
                    l_on      = pend_on_q;
                end else if (bus.i_lcd_wren) begin
                    launch = 1'b1;
                    l_rs   = bus.i_lcd_word[9];
                    l_data = bus.i_lcd_word[7:0];
                    l_on   = bus.i_lcd_word[31];
                end
            end
            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = ST_PULSE;
                    cnt_d   = '0;
                end
            end
            ST_PULSE: begin
                if (cnt_q == EN_LAST) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_EXEC;
                    cnt_d   = '0;
                end
            end
            ST_EXEC: begin
                if (cnt_q == exec_last) begin
`ifdef LCD_INIT_EN
                    if (cur_init_q && init_idx_q != 2'd3) begin
                        launch     = 1'b1;
                        l_data     = init_cmd(init_idx_q + 2'd1);
                        l_on       = 1'b1;
                        init_idx_d = init_idx_q + 2'd1;
                    end else begin
                        done_d     = !cur_init_q;
                        cur_init_d = 1'b0;
                        finish     = 1'b1;
                    end
`else
                    done_d = 1'b1;
                    finish = 1'b1;
`endif
                end
            end
`ifdef LCD_INIT_EN
            ST_INIT_WAIT: begin
                on_d = 1'b1;
                if (cnt_q == INIT_LAST) begin
                    launch     = 1'b1;
                    l_data     = init_cmd(2'd0);
                    l_on       = 1'b1;
                    init_idx_d = 2'd0;
                    cur_init_d = 1'b1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // A finished cycle chains straight into the pending request, skipping IDLE.
        if (finish) begin
            if (pend_vld_q) begin
                launch    = 1'b1;
                from_pend = 1'b1;
                l_rs      = pend_rs_q;
                l_data    = pend_data_q;
                l_on      = pend_on_q;
            end else begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        end

        if (launch) begin
            state_d = ST_SETUP;
            cnt_d   = '0;
            rs_d    = l_rs;
            data_d  = l_data;
            on_d    = l_on;
        end

        if (from_pend) begin
            pend_vld_d = 1'b0;
        end

        if (bus.i_lcd_wren && !direct) begin
            if (pend_vld_q && !from_pend) begin
                ovr_d = 1'b1;
            end
            pend_vld_d  = 1'b1;
            pend_rs_d   = bus.i_lcd_word[9];
            pend_data_d = bus.i_lcd_word[7:0];
            pend_on_d   = bus.i_lcd_word[31];
        end

        en_d = (state_d == ST_PULSE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= RESET_STATE;
            cnt_q       <= '0;
            rs_q        <= 1'b0;
            data_q      <= 8'h00;
            on_q        <= 1'b0;
            en_q        <= 1'b0;
            done_q      <= 1'b0;
            ovr_q       <= 1'b0;
            pend_vld_q  <= 1'b0;
            pend_rs_q   <= 1'b0;
            pend_data_q <= 8'h00;
            pend_on_q   <= 1'b0;
`ifdef LCD_INIT_EN
            init_idx_q  <= 2'd0;
            cur_init_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rs_q        <= rs_d;
            data_q      <= data_d;
            on_q        <= on_d;
            en_q        <= en_d;
            done_q      <= done_d;
            ovr_q       <= ovr_d;
            pend_vld_q  <= pend_vld_d;
            pend_rs_q   <= pend_rs_d;
            pend_data_q <= pend_data_d;
            pend_on_q   <= pend_on_d;
`ifdef LCD_INIT_EN
            init_idx_q  <= init_idx_d;
            cur_init_q  <= cur_init_d;
`endif
        end
    end

    assign bus.o_lcd_data = data_q;
    assign bus.o_lcd_rs   = rs_q;
    assign bus.o_lcd_rw   = 1'b0;
    assign bus.o_lcd_en   = en_q;
    assign bus.o_lcd_on   = on_q;
    assign bus.o_busy     = (state_q != ST_IDLE) || pend_vld_q;
    assign bus.o_done     = done_q;
    assign bus.o_overrun  = ovr_q;

endmodule

// File: tb/tb_lcd_write_ctrl.sv
// Self-checking bench for lcd_write_ctrl with shortened EXEC times.
// Bus writes are checked against a scoreboard queue filled when each strobe is driven.
module tb_lcd_write_ctrl;

    localparam int S        = 4;
    localparam int E        = 12;
    localparam int H        = 4;
    localparam int X        = 50;
    localparam int XL       = 300;
    localparam int LAT      = 1 + S + E + H + X;
    localparam int LAT_LONG = 1 + S + E + H + XL;

    logic clk = 1'b0;
    logic rst = 1'b1;

    lcd_write_if bus();

    lcd_write_ctrl #(
        .SETUP_CYC    (S),
        .EN_CYC       (E),
        .HOLD_CYC     (H),
        .EXEC_CYC     (X),
        .EXEC_LONG_CYC(XL),
        .INIT_WAIT_CYC(100)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
        logic       on;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_exp;
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;
    logic mon_en_prev = 1'b0;
    int   mon_en_run  = 0;

    // Bus monitor: each EN rising edge must match the oldest expected write.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_en_prev = 1'b0;
                mon_en_run  = 0;
            end else begin
                if (bus.o_lcd_en && !mon_en_prev) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL bus_write: got rs=%0b data=%02h on=%0b, expected no write",
                                 bus.o_lcd_rs, bus.o_lcd_data, bus.o_lcd_on);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        if ({bus.o_lcd_rs, bus.o_lcd_data, bus.o_lcd_on} !== mon_exp) begin
                            errors++;
                            $display("FAIL bus_write: got rs=%0b data=%02h on=%0b, expected rs=%0b data=%02h on=%0b",
                                     bus.o_lcd_rs, bus.o_lcd_data, bus.o_lcd_on,
                                     mon_exp.rs, mon_exp.data, mon_exp.on);
                        end
                    end
                end
                if (bus.o_lcd_en) begin
                    mon_en_run++;
                end else if (mon_en_prev) begin
                    checks++;
                    if (mon_en_run != E) begin
                        errors++;
                        $display("FAIL en_width: got %0d cycles, expected %0d", mon_en_run, E);
                    end
                    mon_en_run = 0;
                end
                mon_en_prev = bus.o_lcd_en;
                if (bus.o_done) done_cnt++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the negedge after the strobe edge.
    task automatic strobe(input logic [31:0] w, input bit overwrite);
        exp_t e;
        e.rs   = w[9];
        e.data = w[7:0];
        e.on   = w[31];
        bus.i_lcd_word = w;
        bus.i_lcd_wren = 1'b1;
        if (overwrite) void'(exp_q.pop_back());
        exp_q.push_back(e);
        @(negedge clk);
        bus.i_lcd_wren = 1'b0;
    endtask

    // Sample index 1 is the sample after the strobe edge.
    task automatic run_until_done(input int limit, output int done_edge,
                                  output int en_rise, output int en_len);
        done_edge = -1;
        en_rise   = -1;
        en_len    = 0;
        for (int k = 1; k <= limit; k++) begin
            if (bus.o_lcd_en && en_rise < 0) en_rise = k;
            if (bus.o_lcd_en) en_len++;
            if (bus.o_done) begin
                done_edge = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_lcd_wren = 1'b0;
        bus.i_lcd_word = 32'h0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.o_lcd_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %0b, expected 0", bus.o_lcd_en); end
        checks++;
        if (bus.o_lcd_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %02h, expected 00", bus.o_lcd_data); end
        checks++;
        if ({bus.o_lcd_rs, bus.o_lcd_rw, bus.o_lcd_on} !== 3'b000) begin
            errors++; $display("FAIL reset_rs_rw_on: got %03b, expected 000", {bus.o_lcd_rs, bus.o_lcd_rw, bus.o_lcd_on});
        end
        checks++;
        if ({bus.o_busy, bus.o_done, bus.o_overrun} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %03b, expected 000", {bus.o_busy, bus.o_done, bus.o_overrun});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %0b, expected 0", bus.o_busy); end
    endtask

    task automatic test_single();
        int de, er, el;
        strobe(32'h8000_0241, 1'b0);
        checks++;
        if ({bus.o_lcd_on, bus.o_lcd_rs, bus.o_lcd_data} !== {1'b1, 1'b1, 8'h41}) begin
            errors++; $display("FAIL single_latch: got on=%0b rs=%0b data=%02h, expected on=1 rs=1 data=41",
                               bus.o_lcd_on, bus.o_lcd_rs, bus.o_lcd_data);
        end
        checks++;
        if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %0b, expected 1", bus.o_busy); end
        checks++;
        if (bus.o_lcd_en !== 1'b0) begin errors++; $display("FAIL single_setup_en: got %0b, expected 0", bus.o_lcd_en); end
        run_until_done(LAT + 10, de, er, el);
        checks++;
        if (er != S + 1) begin errors++; $display("FAIL single_en_rise: got %0d, expected %0d", er, S + 1); end
        checks++;
        if (el != E) begin errors++; $display("FAIL single_en_len: got %0d, expected %0d", el, E); end
        checks++;
        if (de != LAT) begin errors++; $display("FAIL single_latency: got %0d, expected %0d", de, LAT); end
        checks++;
        if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %0b, expected 0", bus.o_busy); end
        @(negedge clk);
        checks++;
        if (bus.o_done !== 1'b0) begin errors++; $display("FAIL single_done_pulse: got %0b, expected 0", bus.o_done); end
    endtask

    task automatic test_clear();
        int de, er, el;
        strobe(32'h8000_0001, 1'b0);
        run_until_done(LAT_LONG + 10, de, er, el);
        checks++;
        if (de != LAT_LONG) begin errors++; $display("FAIL clear_latency: got %0d, expected %0d", de, LAT_LONG); end
        checks++;
        if (el != E) begin errors++; $display("FAIL clear_en_len: got %0d, expected %0d", el, E); end
        @(negedge clk);
    endtask

    task automatic test_pending();
        int k, first_done, second_rise, dones;
        strobe(32'h8000_0241, 1'b0);
        k = 0;
        while (!bus.o_lcd_en && k < S + 5) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (bus.o_lcd_en !== 1'b1) begin errors++; $display("FAIL pending_pulse_wait: got en=%0b, expected 1", bus.o_lcd_en); end
        strobe(32'h8000_0242, 1'b0);
        first_done  = -1;
        second_rise = -1;
        dones       = 0;
        for (int i = 0; i < 2 * LAT + 20 && dones < 2; i++) begin
            if (bus.o_done) begin
                dones++;
                if (first_done < 0) first_done = i;
            end
            if (first_done >= 0 && second_rise < 0 && bus.o_lcd_en) second_rise = i;
            @(negedge clk);
        end
        checks++;
        if (dones != 2) begin errors++; $display("FAIL pending_dones: got %0d, expected 2", dones); end
        checks++;
        if (second_rise - first_done != S) begin
            errors++; $display("FAIL pending_chain: got en rise %0d after done, expected %0d", second_rise - first_done, S);
        end
        checks++;
        if (bus.o_overrun !== 1'b0) begin errors++; $display("FAIL pending_overrun: got %0b, expected 0", bus.o_overrun); end
        checks++;
        if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL pending_busy: got %0b, expected 0", bus.o_busy); end
    endtask

    task automatic test_back_to_back();
        int dones;
        strobe(32'h8000_0241, 1'b0);
        strobe(32'h8000_0242, 1'b0);
        strobe(32'h8000_0243, 1'b1);
        checks++;
        if (bus.o_overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun_set: got %0b, expected 1", bus.o_overrun); end
        dones = 0;
        for (int i = 0; i < 3 * LAT && !(dones == 2 && !bus.o_busy); i++) begin
            if (bus.o_done) dones++;
            @(negedge clk);
        end
        repeat (LAT) begin
            if (bus.o_done) dones++;
            @(negedge clk);
        end
        checks++;
        if (dones != 2) begin errors++; $display("FAIL b2b_dones: got %0d, expected 2", dones); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_queue: got %0d left, expected 0", exp_q.size()); end
        checks++;
        if (bus.o_overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun_sticky: got %0b, expected 1", bus.o_overrun); end
    endtask

    task automatic test_reset_mid_pulse();
        int k, d0, de, er, el;
        strobe(32'h8000_0255, 1'b0);
        k = 0;
        while (!bus.o_lcd_en && k < S + 5) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        checks++;
        if (bus.o_lcd_en !== 1'b1) begin errors++; $display("FAIL rstpulse_en_before: got %0b, expected 1", bus.o_lcd_en); end
        d0 = done_cnt;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.o_lcd_en !== 1'b0) begin errors++; $display("FAIL rstpulse_en_async: got %0b, expected 0", bus.o_lcd_en); end
        checks++;
        if ({bus.o_lcd_rs, bus.o_lcd_data, bus.o_lcd_on, bus.o_busy, bus.o_done, bus.o_overrun} !== 13'h0) begin
            errors++; $display("FAIL rstpulse_outputs: got rs=%0b data=%02h on=%0b busy=%0b done=%0b ovr=%0b, expected all 0",
                               bus.o_lcd_rs, bus.o_lcd_data, bus.o_lcd_on, bus.o_busy, bus.o_done, bus.o_overrun);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (done_cnt != d0) begin errors++; $display("FAIL rstpulse_no_done: got %0d pulses, expected 0", done_cnt - d0); end
        strobe(32'h8000_0248, 1'b0);
        run_until_done(LAT + 10, de, er, el);
        checks++;
        if (de != LAT) begin errors++; $display("FAIL rstpulse_recover: got %0d, expected %0d", de, LAT); end
        @(negedge clk);
    endtask

    initial begin
        bus.i_lcd_word = 32'h0;
        bus.i_lcd_wren = 1'b0;
        test_reset();
        test_single();
        test_clear();
        test_pending();
        test_back_to_back();
        test_reset_mid_pulse();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_empty: got %0d left, expected 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
